// File: rtl/enemy_walker.sv
// Walking enemy slot: spawn, walk, fall under gravity, stomp/squish and despawn.
// Motion advances once per frame_clk rising edge; kill and start act immediately.
module enemy_walker #(
  parameter logic [9:0] X_SIZE     = 10'd20,
  parameter logic [9:0] Y_SIZE     = 10'd20,
  parameter logic [9:0] MARIO_HALF = 10'd20,
  parameter logic [9:0] X_STEP     = 10'd1,
  parameter logic [9:0] GRAVITY    = 10'd1,
  parameter logic [9:0] MAX_FALL   = 10'd8,
  parameter logic [9:0] X_MIN      = 10'd120,
  parameter logic [9:0] X_MAX      = 10'd519,
  parameter logic [9:0] Y_MAX      = 10'd439,
  parameter logic [9:0] SHIFT_AMT  = 10'd40,
  parameter int SQUISH_FRAMES      = 6,
  parameter int ANIM_PERIOD        = 16
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       start,
  input  logic       kill,
  input  logic       Shift,
  input  logic       spawn_dir,
  input  logic [9:0] spawnX,
  input  logic [9:0] spawnY,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] Mario_X_Pos,
  input  logic [9:0] Mario_Y_Pos,
  input  logic [2:0] poll_left,
  input  logic [2:0] poll_right,
  input  logic [2:0] poll_down,
  output logic [9:0] X_Pos,
  output logic [9:0] Y_Pos,
  output logic [1:0] state,
  output logic       isAlive,
  output logic       kill_Mario,
  output logic       stomp,
  output logic       draw_is_enemy,
  output logic [1:0] sprite_sel
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK   = 2'd1,
    FALL   = 2'd2,
    SQUISH = 2'd3
  } st_e;

  st_e        st_q, st_d;
  logic [9:0] x_q, x_d, y_q, y_d, yv_q, yv_d;
  logic       dir_q, dir_d;
  logic       km_q, km_d;
  logic       stomp_q, stomp_d;
  logic [1:0] spr_q, spr_d;
  logic [7:0] anim_q, anim_d;
  logic [7:0] sq_q, sq_d;
  logic [1:0] fc_q;
  logic       tick_q;

  logic [9:0] left, right, top, bot;
  logic [9:0] m_top, m_bot, lim_l, lim_r;
  logic [9:0] yv_inc, yv_cap, x_mv;
  logic       hit_stomp, hit_contact, off_field, dir_n, go_idle;

  assign left  = x_q - X_SIZE;
  assign right = x_q + X_SIZE;
  assign top   = y_q - Y_SIZE;
  assign bot   = y_q + Y_SIZE;
  assign m_top = Mario_Y_Pos - MARIO_HALF;
  assign m_bot = Mario_Y_Pos + MARIO_HALF;
  assign lim_l = left - MARIO_HALF;
  assign lim_r = right + MARIO_HALF;

  assign hit_stomp = (m_bot == top) &&
                     (Mario_X_Pos >= left) &&
                     (Mario_X_Pos < right);
  assign hit_contact = (Mario_X_Pos > lim_l) &&
                       (Mario_X_Pos < lim_r) &&
                       (m_bot > top) &&
                       (m_top < bot);
  assign off_field = (right < X_MIN) ||
                     ((st_q == FALL) && (top > Y_MAX));

  assign dir_n = (poll_left != 3'd0) ? 1'b1 :
                 ((poll_right != 3'd0) || (right >= X_MAX)) ? 1'b0 :
                 dir_q;
  assign x_mv  = (dir_n ? x_q + X_STEP : x_q - X_STEP) -
                 (Shift ? SHIFT_AMT : 10'd0);
  assign yv_inc = yv_q + GRAVITY;
  assign yv_cap = (yv_inc > MAX_FALL) ? MAX_FALL : yv_inc;

  always_comb begin
    st_d    = st_q;
    x_d     = x_q;
    y_d     = y_q;
    yv_d    = yv_q;
    dir_d   = dir_q;
    km_d    = km_q;
    stomp_d = 1'b0;
    spr_d   = spr_q;
    anim_d  = anim_q;
    sq_d    = sq_q;
    go_idle = 1'b0;
    if (kill) begin
      go_idle = 1'b1;
      km_d    = 1'b0;
    end else if (start) begin
      st_d   = WALK;
      x_d    = spawnX;
      y_d    = spawnY - Y_SIZE;
      yv_d   = '0;
      dir_d  = spawn_dir;
      km_d   = 1'b0;
      spr_d  = 2'd0;
      anim_d = '0;
      sq_d   = '0;
    end else if (tick_q) begin
      unique case (st_q)
        WALK, FALL: begin
          if (hit_stomp) begin
            st_d    = SQUISH;
            sq_d    = 8'(SQUISH_FRAMES - 1);
            stomp_d = 1'b1;
            spr_d   = 2'd2;
          end else if (hit_contact) begin
            km_d = 1'b1;
          end else if (off_field) begin
            go_idle = 1'b1;
          end else begin
            dir_d = dir_n;
            x_d   = x_mv;
            if (st_q == WALK) begin
              if (poll_down == 3'd0) begin
                st_d = FALL;
                yv_d = '0;
              end
            end else if (poll_down != 3'd0) begin
              st_d = WALK;
              yv_d = '0;
            end else begin
              yv_d = yv_cap;
              y_d  = y_q + yv_cap;
            end
            if (anim_q == 8'(ANIM_PERIOD - 1)) begin
              anim_d = '0;
              spr_d  = {1'b0, ~spr_q[0]};
            end else begin
              anim_d = anim_q + 8'd1;
            end
          end
        end
        SQUISH: begin
          if (Shift) x_d = x_q - SHIFT_AMT;
          if (sq_q == 8'd0) go_idle = 1'b1;
          else sq_d = sq_q - 8'd1;
        end
        default: ;
      endcase
    end
    // despawn returns every slot register except the sticky kill flag
    if (go_idle) begin
      st_d   = IDLE;
      x_d    = '0;
      y_d    = '0;
      yv_d   = '0;
      dir_d  = 1'b0;
      spr_d  = 2'd0;
      anim_d = '0;
      sq_d   = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fc_q    <= '0;
      tick_q  <= 1'b0;
      st_q    <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      yv_q    <= '0;
      dir_q   <= 1'b0;
      km_q    <= 1'b0;
      stomp_q <= 1'b0;
      spr_q   <= 2'd0;
      anim_q  <= '0;
      sq_q    <= '0;
    end else begin
      fc_q    <= {fc_q[0], frame_clk};
      tick_q  <= fc_q[0] & ~fc_q[1];
      st_q    <= st_d;
      x_q     <= x_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
      dir_q   <= dir_d;
      km_q    <= km_d;
      stomp_q <= stomp_d;
      spr_q   <= spr_d;
      anim_q  <= anim_d;
      sq_q    <= sq_d;
    end
  end

  logic in_x, in_y;
  assign in_x = (DrawX >= left) && (DrawX < right);
  assign in_y = (st_q == SQUISH) ? ((DrawY >= y_q) && (DrawY < bot)) :
                                   ((DrawY >= top) && (DrawY < bot));

  assign draw_is_enemy = (st_q != IDLE) && in_x && in_y;
  assign X_Pos         = x_q;
  assign Y_Pos         = y_q;
  assign state         = st_q;
  assign isAlive       = (st_q != IDLE);
  assign kill_Mario    = km_q;
  assign stomp         = stomp_q;
  assign sprite_sel    = spr_q;

endmodule

// File: tb/tb_enemy_walker.sv
// Bench for enemy_walker: directed scenarios then random frames
// against an integer reference model of the enemy's frame rules.
module tb_enemy_walker;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic       start = 1'b0, kill = 1'b0, Shift = 1'b0, spawn_dir = 1'b0;
  logic [9:0] spawnX = '0, spawnY = '0, DrawX = '0, DrawY = '0;
  logic [9:0] Mario_X_Pos = '0, Mario_Y_Pos = '0;
  logic [2:0] poll_left = '0, poll_right = '0, poll_down = 3'd1;
  logic [9:0] X_Pos, Y_Pos;
  logic [1:0] state, sprite_sel;
  logic       isAlive, kill_Mario, stomp, draw_is_enemy;

  enemy_walker dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .start(start), .kill(kill), .Shift(Shift), .spawn_dir(spawn_dir),
    .spawnX(spawnX), .spawnY(spawnY), .DrawX(DrawX), .DrawY(DrawY),
    .Mario_X_Pos(Mario_X_Pos), .Mario_Y_Pos(Mario_Y_Pos),
    .poll_left(poll_left), .poll_right(poll_right), .poll_down(poll_down),
    .X_Pos(X_Pos), .Y_Pos(Y_Pos), .state(state), .isAlive(isAlive),
    .kill_Mario(kill_Mario), .stomp(stomp),
    .draw_is_enemy(draw_is_enemy), .sprite_sel(sprite_sel)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: 0 idle, 1 walk, 2 fall, 3 squish
  int m_st, m_x, m_y, m_yv, m_dir, m_km, m_spr, m_anim, m_tmr, m_stomp;

  function automatic int w(input int v);
    return v & 1023;
  endfunction

  task automatic m_idle();
    m_st = 0; m_x = 0; m_y = 0; m_yv = 0; m_dir = 0;
    m_spr = 0; m_anim = 0; m_tmr = 0;
  endtask

  task automatic m_reset();
    m_idle();
    m_km = 0;
    m_stomp = 0;
  endtask

  task automatic m_start(input int sx, input int sy, input int sd);
    m_st = 1; m_x = sx; m_y = w(sy - 20); m_dir = sd; m_yv = 0;
    m_km = 0; m_spr = 0; m_anim = 0; m_tmr = 0;
  endtask

  task automatic m_tick();
    int mx, my, l, r, t, b;
    mx = int'(Mario_X_Pos);
    my = int'(Mario_Y_Pos);
    m_stomp = 0;
    l = w(m_x - 20); r = w(m_x + 20);
    t = w(m_y - 20); b = w(m_y + 20);
    if (m_st == 1 || m_st == 2) begin
      if (w(my + 20) == t && mx >= l && mx < r) begin
        m_st = 3; m_tmr = 5; m_stomp = 1; m_spr = 2;
      end else if (mx > w(l - 20) && mx < w(r + 20) &&
                   w(my + 20) > t && w(my - 20) < b) begin
        m_km = 1;
      end else if (r < 120 || (m_st == 2 && t > 439)) begin
        m_idle();
      end else begin
        if (poll_left != 0) m_dir = 1;
        else if (poll_right != 0 || r >= 519) m_dir = 0;
        m_x = w(m_x + (m_dir == 1 ? 1 : -1) - (Shift ? 40 : 0));
        if (m_st == 1) begin
          if (poll_down == 0) begin m_st = 2; m_yv = 0; end
        end else if (poll_down != 0) begin
          m_st = 1; m_yv = 0;
        end else begin
          m_yv = (m_yv + 1 > 8) ? 8 : m_yv + 1;
          m_y = w(m_y + m_yv);
        end
        m_anim++;
        if (m_anim == 16) begin m_anim = 0; m_spr = 1 - m_spr; end
      end
    end else if (m_st == 3) begin
      if (Shift) m_x = w(m_x - 40);
      if (m_tmr == 0) m_idle();
      else m_tmr--;
    end
  endtask

  task automatic chk_draw();
    int dx, dy, e, l, r;
    dx = w(m_x + $urandom_range(0, 50) - 25);
    dy = w(m_y + $urandom_range(0, 50) - 25);
    DrawX = dx[9:0];
    DrawY = dy[9:0];
    #1;
    l = w(m_x - 20); r = w(m_x + 20);
    e = 0;
    if (m_st != 0 && dx >= l && dx < r) begin
      if (m_st == 3) e = (dy >= m_y && dy < w(m_y + 20)) ? 1 : 0;
      else e = (dy >= w(m_y - 20) && dy < w(m_y + 20)) ? 1 : 0;
    end
    chk("draw", int'(draw_is_enemy), e);
  endtask

  task automatic chk_all();
    chk("state", int'(state), m_st);
    chk("x", int'(X_Pos), m_x);
    chk("y", int'(Y_Pos), m_y);
    chk("kill_mario", int'(kill_Mario), m_km);
    chk("sprite", int'(sprite_sel), m_spr);
    chk("alive", int'(isAlive), (m_st != 0) ? 1 : 0);
    chk_draw();
    chk_draw();
  endtask

  task automatic frame();
    int sc;
    sc = 0;
    m_tick();
    @(negedge Clk);
    frame_clk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      sc += int'(stomp);
      if (i == 2) frame_clk = 1'b0;
    end
    chk("stomp_pulse", sc, m_stomp);
    chk_all();
  endtask

  task automatic do_start(input int sx, input int sy, input int sd);
    @(negedge Clk);
    spawnX = sx[9:0]; spawnY = sy[9:0]; spawn_dir = sd[0];
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    m_start(sx, sy, sd);
    m_stomp = 0;
    chk("start_stomp", int'(stomp), 0);
    chk_all();
  endtask

  task automatic do_kill();
    @(negedge Clk);
    kill = 1'b1;
    @(negedge Clk);
    kill = 1'b0;
    m_reset();
    chk("kill_stomp", int'(stomp), 0);
    chk_all();
  endtask

  task automatic mario(input int mx, input int my);
    Mario_X_Pos = w(mx);
    Mario_Y_Pos = w(my);
  endtask

  initial begin
    m_reset();
    mario(0, 0);
    #12;
    chk("rst_state", int'(state), 0);
    chk("rst_x", int'(X_Pos), 0);
    chk("rst_stomp", int'(stomp), 0);
    chk_all();
    @(negedge Clk);
    Reset_n = 1'b1;

    // spawn and walk left
    do_start(300, 400, 0);
    chk("spawn_x", int'(X_Pos), 300);
    chk("spawn_y", int'(Y_Pos), 380);
    repeat (5) frame();
    chk("walk5_x", int'(X_Pos), 295);

    // wall bounce
    do_start(200, 400, 0);
    poll_left = 3'b001;
    frame();
    poll_left = 3'b000;
    chk("wall_x", int'(X_Pos), 201);
    frame();
    chk("wall_x2", int'(X_Pos), 202);

    // fall and land
    do_start(300, 400, 0);
    poll_down = 3'd0;
    repeat (4) frame();
    chk("fall_y", int'(Y_Pos), 386);
    chk("fall_st", int'(state), 2);
    poll_down = 3'd2;
    frame();
    chk("land_y", int'(Y_Pos), 386);
    chk("land_st", int'(state), 1);

    // async reset mid-fall
    poll_down = 3'd0;
    frame();
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    m_reset();
    chk("arst_state", int'(state), 0);
    chk_all();
    @(negedge Clk);
    Reset_n = 1'b1;
    poll_down = 3'd1;

    // stomp, squish for six frames
    do_start(300, 400, 0);
    mario(300, 340);
    frame();
    chk("stomp_st", int'(state), 3);
    mario(0, 0);
    repeat (5) frame();
    chk("squish_alive", int'(isAlive), 1);
    frame();
    chk("squish_end", int'(isAlive), 0);

    // kill during squish
    do_start(300, 400, 1);
    mario(300, 340);
    frame();
    mario(0, 0);
    frame();
    do_kill();

    // contact is sticky until start
    do_start(300, 400, 0);
    mario(260, 380);
    repeat (3) frame();
    chk("contact", int'(kill_Mario), 1);
    mario(0, 0);
    repeat (2) frame();
    chk("contact_held", int'(kill_Mario), 1);
    do_start(300, 400, 0);
    chk("contact_clr", int'(kill_Mario), 0);

    // start overlapping a frame edge wins
    @(negedge Clk);
    spawnX = 10'd350; spawnY = 10'd300; spawn_dir = 1'b1;
    start = 1'b1;
    frame_clk = 1'b1;
    repeat (6) @(negedge Clk);
    start = 1'b0;
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    m_start(350, 300, 1);
    chk_all();

    // random frames
    for (int n = 0; n < 400; n++) begin
      int p;
      p = $urandom_range(0, 99);
      if (m_st == 0 && $urandom_range(0, 2) == 0 || p < 2)
        do_start($urandom_range(100, 520), $urandom_range(50, 450),
                 $urandom_range(0, 1));
      else if (p < 3)
        do_kill();
      p = $urandom_range(0, 15);
      if (p < 2)
        mario(m_x - 20 + $urandom_range(0, 39), m_y - 40);
      else if (p < 6)
        mario(m_x - 50 + $urandom_range(0, 100),
              m_y - 60 + $urandom_range(0, 120));
      else
        mario($urandom_range(0, 1023), $urandom_range(0, 1023));
      poll_left  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      poll_right = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      if ($urandom_range(0, 7) == 0) poll_down = ~|poll_down ? 3'd4 : 3'd0;
      Shift = ($urandom_range(0, 19) == 0);
      frame();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
